// File: rtl/capture_pkg.sv
// Shared types and default widths for the logic-analyzer capture sequencer.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int DATAW = 32;
  localparam int LENW  = 16;
  localparam int DIVW  = 16;

endpackage

// File: rtl/capture_trigger.sv
// Sample-rate divider plus masked level/edge trigger detection for capture_ctrl.
module capture_trigger
  import capture_pkg::*;
#(
  parameter int dataw = DATAW,
  parameter int divw  = DIVW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             active,
  input  logic [dataw-1:0] sample_in,
  input  logic [dataw-1:0] trig_mask,
  input  logic [dataw-1:0] trig_value,
  input  logic             trig_edge,
  input  logic [divw-1:0]  div,
  output logic             strobe,
  output logic             trig
);

  logic [divw-1:0] count;
  logic            match;
  logic            prev_match;
  logic            primed;

  assign match  = ((sample_in ^ trig_value) & trig_mask) == '0;
  assign strobe = active && (count == div);

  // An edge needs one observed strobe first, so a level already matching at
  // arm (or an all-zero mask) is never mistaken for a rising match.
  assign trig = strobe && (trig_edge ? (primed && match && !prev_match) : match);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      prev_match <= 1'b0;
      primed     <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      prev_match <= 1'b0;
      primed     <= 1'b0;
    end else if (active) begin
      count <= strobe ? '0 : count + 1'b1;
      if (strobe) begin
        prev_match <= match;
        primed     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: arms on a pulse, waits for a trigger, then streams a fixed
// number of probe samples into the capture FIFO, dropping beats it cannot stall.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int dataw = DATAW,
  parameter int lenw  = LENW,
  parameter int divw  = DIVW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [dataw-1:0] sample_in,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic [dataw-1:0] cfg_trig_mask,
  input  logic [dataw-1:0] cfg_trig_value,
  input  logic             cfg_trig_edge,
  input  logic [divw-1:0]  cfg_div,
  input  logic [lenw-1:0]  cfg_len,
  output logic [dataw-1:0] fifo_tdata,
  output logic             fifo_tvalid,
  input  logic             fifo_tready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [lenw:0]    captured
);

  localparam logic [lenw:0] CAPTURED_MAX = {1'b1, {lenw{1'b0}}};

  cap_state_t       state;
  logic [dataw-1:0] mask_q;
  logic [dataw-1:0] value_q;
  logic             edge_q;
  logic [divw-1:0]  div_q;
  logic [lenw-1:0]  len_cnt;
  logic             active;
  logic             arm_ok;
  logic             strobe;
  logic             trig;
  logic             emit;

  assign active = (state == ARMED) || (state == CAPTURE);
  assign arm_ok = cfg_arm && !cfg_abort && ((state == IDLE) || (state == DONE));
  assign emit   = ((state == ARMED) && trig) || ((state == CAPTURE) && strobe);

  capture_trigger #(
    .dataw(dataw),
    .divw (divw)
  ) u_trigger (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (arm_ok),
    .active    (active),
    .sample_in (sample_in),
    .trig_mask (mask_q),
    .trig_value(value_q),
    .trig_edge (edge_q),
    .div       (div_q),
    .strobe    (strobe),
    .trig      (trig)
  );

  // Beats are never held: whatever the FIFO does not take in the valid cycle is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= 1'b0;
      div_q       <= '0;
      len_cnt     <= '0;
      fifo_tdata  <= '0;
      fifo_tvalid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      captured    <= '0;
    end else begin
      if (fifo_tvalid) begin
        if (fifo_tready) begin
          if (captured != CAPTURED_MAX) captured <= captured + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (emit) fifo_tdata <= sample_in;
      fifo_tvalid <= emit;

      if (cfg_abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        done        <= 1'b0;
        fifo_tvalid <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (cfg_arm) begin
              state    <= ARMED;
              busy     <= 1'b1;
              done     <= 1'b0;
              mask_q   <= cfg_trig_mask;
              value_q  <= cfg_trig_value;
              edge_q   <= cfg_trig_edge;
              div_q    <= cfg_div;
              len_cnt  <= cfg_len;
              overflow <= 1'b0;
              captured <= '0;
            end
          end
          ARMED, CAPTURE: begin
            if (emit) begin
              if (len_cnt == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= CAPTURE;
                len_cnt <= len_cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: trigger modes, divider, overflow, abort, reset and re-arm.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] sample_in;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [31:0] cfg_trig_mask;
  logic [31:0] cfg_trig_value;
  logic        cfg_trig_edge;
  logic [15:0] cfg_div;
  logic [15:0] cfg_len;
  logic [31:0] fifo_tdata;
  logic        fifo_tvalid;
  logic        fifo_tready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [16:0] captured;

  int checks = 0;
  int errors = 0;

  capture_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .sample_in     (sample_in),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_trig_mask (cfg_trig_mask),
    .cfg_trig_value(cfg_trig_value),
    .cfg_trig_edge (cfg_trig_edge),
    .cfg_div       (cfg_div),
    .cfg_len       (cfg_len),
    .fifo_tdata    (fifo_tdata),
    .fifo_tvalid   (fifo_tvalid),
    .fifo_tready   (fifo_tready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .captured      (captured)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_arm(input logic [31:0] mask, input logic [31:0] value,
                           input logic edge_mode, input logic [15:0] div,
                           input logic [15:0] len);
    cfg_trig_mask  = mask;
    cfg_trig_value = value;
    cfg_trig_edge  = edge_mode;
    cfg_div        = div;
    cfg_len        = len;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic apply_abort();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  initial begin
    logic [31:0] lvl_beats [4];
    lvl_beats = '{32'h5A, 32'h5B, 32'h5C, 32'h5D};

    resetn         = 1'b1;
    sample_in      = '0;
    cfg_arm        = 1'b0;
    cfg_abort      = 1'b0;
    cfg_trig_mask  = '0;
    cfg_trig_value = '0;
    cfg_trig_edge  = 1'b0;
    cfg_div        = '0;
    cfg_len        = '0;
    fifo_tready    = 1'b1;

    #2 resetn = 1'b0;
    #1;
    check_output("rst_tvalid", 64'(fifo_tvalid), 64'd0);
    check_output("rst_tdata", 64'(fifo_tdata), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_captured", 64'(captured), 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check_output("idle_busy", 64'(busy), 64'd0);

    // Level trigger, back-to-back beats.
    apply_arm(32'hFF, 32'h5A, 1'b0, 16'd0, 16'd3);
    check_output("lvl_armed_busy", 64'(busy), 64'd1);
    tick();
    check_output("lvl_no_trig", 64'(fifo_tvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      sample_in = lvl_beats[i];
      tick();
      check_output("lvl_tvalid", 64'(fifo_tvalid), 64'd1);
      check_output("lvl_tdata", 64'(fifo_tdata), 64'(lvl_beats[i]));
      check_output("lvl_done", 64'(done), (i == 3) ? 64'd1 : 64'd0);
    end
    sample_in = '0;
    tick();
    check_output("lvl_end_tvalid", 64'(fifo_tvalid), 64'd0);
    check_output("lvl_captured", 64'(captured), 64'd4);
    check_output("lvl_done_hold", 64'(done), 64'd1);
    check_output("lvl_overflow", 64'(overflow), 64'd0);
    check_output("lvl_busy", 64'(busy), 64'd0);

    // Edge trigger: bit0 already high at arm must not count as a rising match.
    sample_in = 32'h1;
    apply_arm(32'h1, 32'h1, 1'b1, 16'd0, 16'd0);
    tick();
    check_output("edge_held_high", 64'(fifo_tvalid), 64'd0);
    sample_in = 32'h0;
    tick();
    check_output("edge_low", 64'(fifo_tvalid), 64'd0);
    sample_in = 32'h5;
    tick();
    check_output("edge_tvalid", 64'(fifo_tvalid), 64'd1);
    check_output("edge_tdata", 64'(fifo_tdata), 64'h5);
    check_output("edge_done", 64'(done), 64'd1);
    tick();
    check_output("edge_captured", 64'(captured), 64'd1);

    // Edge mode with an all-zero mask never triggers; only abort exits.
    apply_arm(32'h0, 32'h0, 1'b1, 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      sample_in = 32'(i);
      tick();
      check_output("edge0_no_trig", 64'(fifo_tvalid), 64'd0);
    end
    check_output("edge0_busy", 64'(busy), 64'd1);
    apply_abort();
    check_output("edge0_abort_busy", 64'(busy), 64'd0);
    check_output("edge0_abort_done", 64'(done), 64'd0);

    // Divider: beats every four clocks.
    sample_in = 32'hA1;
    apply_arm(32'h0, 32'h0, 1'b0, 16'd3, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("div_gap1", 64'(fifo_tvalid), 64'd0);
    end
    tick();
    check_output("div_beat1", 64'(fifo_tvalid), 64'd1);
    check_output("div_tdata1", 64'(fifo_tdata), 64'hA1);
    check_output("div_done1", 64'(done), 64'd0);
    sample_in = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("div_gap2", 64'(fifo_tvalid), 64'd0);
    end
    tick();
    check_output("div_beat2", 64'(fifo_tvalid), 64'd1);
    check_output("div_tdata2", 64'(fifo_tdata), 64'hA2);
    check_output("div_done2", 64'(done), 64'd1);
    tick();
    check_output("div_captured", 64'(captured), 64'd2);

    // Overflow: beats 3 and 4 refused by the FIFO.
    apply_arm(32'h0, 32'h0, 1'b0, 16'd0, 16'd7);
    for (int i = 0; i < 8; i++) begin
      sample_in = 32'h10 + 32'(i);
      tick();
      check_output("ovf_tvalid", 64'(fifo_tvalid), 64'd1);
      check_output("ovf_tdata", 64'(fifo_tdata), 64'h10 + 64'(i));
      fifo_tready = (i == 2 || i == 3) ? 1'b0 : 1'b1;
    end
    fifo_tready = 1'b1;
    tick();
    check_output("ovf_end_tvalid", 64'(fifo_tvalid), 64'd0);
    check_output("ovf_captured", 64'(captured), 64'd6);
    check_output("ovf_overflow", 64'(overflow), 64'd1);
    check_output("ovf_done", 64'(done), 64'd1);
    sample_in = '0;
    apply_arm(32'hFF, 32'hEE, 1'b0, 16'd0, 16'd0);
    check_output("rearm_overflow", 64'(overflow), 64'd0);
    check_output("rearm_captured", 64'(captured), 64'd0);
    check_output("rearm_busy", 64'(busy), 64'd1);
    check_output("rearm_done", 64'(done), 64'd0);
    apply_abort();

    // Abort mid-capture.
    apply_arm(32'h0, 32'h0, 1'b0, 16'd0, 16'd7);
    sample_in = 32'h20;
    tick();
    sample_in = 32'h21;
    tick();
    check_output("abort_pre_tvalid", 64'(fifo_tvalid), 64'd1);
    check_output("abort_pre_captured", 64'(captured), 64'd1);
    apply_abort();
    check_output("abort_tvalid", 64'(fifo_tvalid), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    tick();
    tick();
    check_output("abort_quiet", 64'(fifo_tvalid), 64'd0);

    // Asynchronous reset mid-capture.
    apply_arm(32'h0, 32'h0, 1'b0, 16'd0, 16'd7);
    tick();
    tick();
    check_output("mrst_pre_busy", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check_output("mrst_tvalid", 64'(fifo_tvalid), 64'd0);
    check_output("mrst_tdata", 64'(fifo_tdata), 64'd0);
    check_output("mrst_busy", 64'(busy), 64'd0);
    check_output("mrst_done", 64'(done), 64'd0);
    check_output("mrst_overflow", 64'(overflow), 64'd0);
    check_output("mrst_captured", 64'(captured), 64'd0);
    #2 resetn = 1'b1;
    tick();

    // Arm while busy is ignored: original length of four beats stands.
    sample_in = '0;
    apply_arm(32'hFF, 32'h77, 1'b0, 16'd0, 16'd3);
    cfg_len = 16'd0;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check_output("busyarm_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      sample_in = 32'h77 | (32'(i) << 8);
      tick();
      check_output("busyarm_tvalid", 64'(fifo_tvalid), 64'd1);
      check_output("busyarm_done", 64'(done), (i == 3) ? 64'd1 : 64'd0);
    end
    tick();
    check_output("busyarm_captured", 64'(captured), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
